uncached_write_buffer: RTL and testbench

- Posted-write buffer between the CPU data SRAM-like port and the data port of `sram_to_axi`.
- Uncached stores are acknowledged early: upstream `data_ok` comes one cycle after acceptance. The buffer then drains them in order to the AXI bridge.
- Every other request (cached access, uncached load) is forwarded only when the buffer is empty and idle. This preserves program order towards the bus.
- Instantiated inside `mycpu_top` on the data path only.

---
 rtl/ucwb_pkg.sv | 13 +
 rtl/ucwb_fifo.sv | 40 ++++
 rtl/uncached_write_buffer.sv | 100 ++++++++++
 tb/tb_uncached_write_buffer.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ucwb_pkg.sv
// ucwb_pkg: shared entry type and state encodings for the uncached write buffer
package ucwb_pkg;
  localparam int UCWB_AW = 32;
  localparam int UCWB_DW = 32;
  typedef struct packed {
    logic [UCWB_AW-1:0] addr;
    logic [1:0] size;
    logic [3:0] wstrb;
    logic [UCWB_DW-1:0] wdata;
  } ucwb_entry_t;
  typedef enum logic [1:0] {D_IDLE, D_REQ, D_RESP} drain_t;
  typedef enum logic {P_IDLE, P_WAIT} pass_t;
endpackage

// File: rtl/ucwb_fifo.sv
// ucwb_fifo: DEPTH-entry synchronous FIFO of buffered store entries with head output
module ucwb_fifo
  import ucwb_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  ucwb_entry_t din,
  output ucwb_entry_t head,
  output logic full,
  output logic empty,
  output logic [CW-1:0] count
);
  ucwb_entry_t mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  assign head = mem[rd_ptr];
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  // entry storage, written at the tail
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end
  // pointers wrap naturally; simultaneous push and pop keep count unchanged
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: rtl/uncached_write_buffer.sv
// uncached_write_buffer: posted uncached-store buffer in front of sram_to_axi; UCWB_PERF_EN adds stall counters
module uncached_write_buffer
  import ucwb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW = UCWB_AW,
  parameter int DW = UCWB_DW
) (
  input  logic clk,
  input  logic reset,
  input  logic u_req,
  input  logic u_uncached,
  input  logic u_wr,
  input  logic [1:0] u_size,
  input  logic [3:0] u_wstrb,
  input  logic [AW-1:0] u_addr,
  input  logic [DW-1:0] u_wdata,
  output logic u_addr_ok,
  output logic u_data_ok,
  output logic [DW-1:0] u_rdata,
  output logic d_req,
  output logic d_uncached,
  output logic d_wr,
  output logic [1:0] d_size,
  output logic [3:0] d_wstrb,
  output logic [AW-1:0] d_addr,
  output logic [DW-1:0] d_wdata,
  input  logic d_addr_ok,
  input  logic d_data_ok,
  input  logic [DW-1:0] d_rdata,
  output logic wb_empty
`ifdef UCWB_PERF_EN
  ,
  output logic [31:0] perf_full_stall,
  output logic [31:0] perf_pass_stall
`endif
);
  localparam int CW = $clog2(DEPTH + 1);
  drain_t drain;
  pass_t pass;
  logic ack_q, full, empty, store, pass_req, pass_ok, pass_hs, push, pop, own;
  logic [CW-1:0] count;
  ucwb_entry_t head, din;
  assign store = u_req & u_uncached & u_wr;
  assign pass_req = u_req & ~store;
  assign own = ~empty | drain != D_IDLE;
  assign pass_ok = ~own & pass == P_IDLE;
  assign pass_hs = pass_req & pass_ok & d_addr_ok;
  assign push = store & ~full & pass == P_IDLE;
  assign pop = drain == D_RESP & d_data_ok;
  assign din = '{addr: u_addr, size: u_size, wstrb: u_wstrb, wdata: u_wdata};
  assign u_addr_ok = push | pass_hs;
  assign u_data_ok = ack_q | (pass == P_WAIT & d_data_ok);
  assign u_rdata = d_rdata;
  assign d_req = ~reset & (own ? drain == D_REQ : pass_req & pass_ok);
  assign d_uncached = own | u_uncached;
  assign d_wr = own | u_wr;
  assign d_size = own ? head.size : u_size;
  assign d_wstrb = own ? head.wstrb : u_wstrb;
  assign d_addr = own ? head.addr : u_addr;
  assign d_wdata = own ? head.wdata : u_wdata;
  assign wb_empty = ~own;
  ucwb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(reset),
    .push(push),
    .pop(pop),
    .din(din),
    .head(head),
    .full(full),
    .empty(empty),
    .count(count)
  );
  // drain and pass-through FSMs plus the early store acknowledge
  always_ff @(posedge clk) begin
    if (reset) begin
      drain <= D_IDLE;
      pass <= P_IDLE;
      ack_q <= 1'b0;
    end else begin
      ack_q <= push;
      drain <= drain == D_IDLE ? (empty ? D_IDLE : D_REQ) :
               drain == D_REQ ? (d_addr_ok ? D_RESP : D_REQ) :
               d_data_ok ? (count != CW'(1) ? D_REQ : D_IDLE) : D_RESP;
      pass <= pass == P_IDLE ? (pass_hs ? P_WAIT : P_IDLE) : (d_data_ok ? P_IDLE : P_WAIT);
    end
  end
`ifdef UCWB_PERF_EN
  // saturating stall counters: store against a full buffer, pass-through behind buffered stores
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_full_stall <= '0;
      perf_pass_stall <= '0;
    end else begin
      if (store & full & ~&perf_full_stall) perf_full_stall <= perf_full_stall + 32'd1;
      if (pass_req & own & ~&perf_pass_stall) perf_pass_stall <= perf_pass_stall + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_uncached_write_buffer.sv
// tb_uncached_write_buffer: scoreboard bench for the uncached write buffer with a modelled downstream bridge
module tb_uncached_write_buffer;
  import ucwb_pkg::*;
  logic clk = 1'b0;
  logic reset, u_req, u_uncached, u_wr, u_addr_ok, u_data_ok;
  logic [1:0] u_size, d_size;
  logic [3:0] u_wstrb, d_wstrb;
  logic [31:0] u_addr, u_wdata, u_rdata, d_addr, d_wdata, d_rdata;
  logic d_req, d_uncached, d_wr, d_addr_ok, d_data_ok, wb_empty;
`ifdef UCWB_PERF_EN
  logic [31:0] perf_full_stall, perf_pass_stall;
`endif
  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0] wstrb;
    logic [1:0] size;
    logic wr;
    logic unc;
  } dreq_t;
  typedef struct {
    logic chk;
    logic [31:0] rdata;
  } uresp_t;
  dreq_t exp_d[$];
  uresp_t exp_u[$];
  int checks = 0, errors = 0, dresp_cnt = 0;
  int lat = 0, rlat = 0, wcnt = 0, rcnt = 0;
  int w, base, n;
  bit ready = 1'b1, pend = 1'b0, shs;
  logic prev_store_acc = 1'b0;
  logic [31:0] rdata_val = '0;

  assign d_rdata = rdata_val;
  always #5 clk = ~clk;

  uncached_write_buffer dut (
    .clk(clk), .reset(reset),
    .u_req(u_req), .u_uncached(u_uncached), .u_wr(u_wr), .u_size(u_size),
    .u_wstrb(u_wstrb), .u_addr(u_addr), .u_wdata(u_wdata),
    .u_addr_ok(u_addr_ok), .u_data_ok(u_data_ok), .u_rdata(u_rdata),
    .d_req(d_req), .d_uncached(d_uncached), .d_wr(d_wr), .d_size(d_size),
    .d_wstrb(d_wstrb), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok), .d_rdata(d_rdata),
    .wb_empty(wb_empty)
`ifdef UCWB_PERF_EN
    , .perf_full_stall(perf_full_stall), .perf_pass_stall(perf_pass_stall)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] st,
                       input logic wr, input logic unc, input logic [1:0] sz,
                       input logic [31:0] erd, output int waits);
    exp_d.push_back('{addr: a, wdata: wd, wstrb: st, size: sz, wr: wr, unc: unc});
    exp_u.push_back('{chk: !(wr & unc), rdata: erd});
    u_req = 1'b1; u_addr = a; u_wdata = wd; u_wstrb = st; u_wr = wr; u_uncached = unc; u_size = sz;
    waits = 0;
    forever begin
      @(negedge clk);
      if (u_addr_ok) break;
      waits++;
      if (waits > 100) begin
        checks++; errors++;
        $display("FAIL issue_timeout: addr %h not accepted within 100 cycles", a);
        break;
      end
    end
    step(1);
    u_req = 1'b0;
  endtask

  task automatic wait_empty(input string name);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(wb_empty && exp_d.size() == 0 && exp_u.size() == 0) && k < 200);
    chk(name, {63'd0, wb_empty && exp_d.size() == 0 && exp_u.size() == 0}, 64'd1);
    step(1);
  endtask

  task automatic wait_hs(input string name);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(d_req && d_addr_ok) && k < 50);
    chk(name, {63'd0, d_req && d_addr_ok}, 64'd1);
  endtask

  // downstream bridge model: request accept after lat cycles, response rlat cycles after accept
  initial begin
    d_addr_ok = 1'b0;
    d_data_ok = 1'b0;
    forever begin
      @(negedge clk);
      shs = d_req & d_addr_ok;
      @(posedge clk);
      #2;
      d_data_ok = 1'b0;
      if (reset) begin
        pend = 1'b0; wcnt = 0; d_addr_ok = 1'b0;
      end else begin
        if (shs) begin pend = 1'b1; rcnt = 0; wcnt = 0; end
        if (pend) begin
          if (rcnt >= rlat) begin d_data_ok = 1'b1; pend = 1'b0; end
          else rcnt++;
        end
        d_addr_ok = d_req & ready & (wcnt >= lat);
        if (d_req & ready & (wcnt < lat)) wcnt++;
      end
    end
  end

  // monitor: downstream requests and upstream responses against the scoreboard queues
  always @(negedge clk) begin
    dreq_t r;
    uresp_t u;
    if (reset) prev_store_acc = 1'b0;
    else begin
      if (d_req && d_addr_ok) begin
        if (exp_d.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_dreq: addr %h with nothing expected", d_addr);
        end else begin
          r = exp_d.pop_front();
          chk("d_addr", {32'd0, d_addr}, {32'd0, r.addr});
          chk("d_wdata", {32'd0, d_wdata}, {32'd0, r.wdata});
          chk("d_wstrb", {60'd0, d_wstrb}, {60'd0, r.wstrb});
          chk("d_size", {62'd0, d_size}, {62'd0, r.size});
          chk("d_wr", {63'd0, d_wr}, {63'd0, r.wr});
          chk("d_uncached", {63'd0, d_uncached}, {63'd0, r.unc});
        end
      end
      if (d_data_ok) dresp_cnt++;
      if (prev_store_acc) chk("store_ack_next_cycle", {63'd0, u_data_ok}, 64'd1);
      if (u_data_ok) begin
        if (exp_u.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_uresp: u_data_ok with nothing expected");
        end else begin
          u = exp_u.pop_front();
          chk("ack_kind", {63'd0, prev_store_acc}, {63'd0, !u.chk});
          if (u.chk) begin
            chk("u_rdata", {32'd0, u_rdata}, {32'd0, u.rdata});
            chk("pass_resp_on_d_data_ok", {63'd0, d_data_ok}, 64'd1);
          end
        end
      end
      prev_store_acc = u_req & u_uncached & u_wr & u_addr_ok;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; u_req = 1'b0; u_uncached = 1'b0; u_wr = 1'b0;
    u_size = '0; u_wstrb = '0; u_addr = '0; u_wdata = '0;
    step(3);
    @(negedge clk);
    chk("reset_d_req", {63'd0, d_req}, 64'd0);
    chk("reset_wb_empty", {63'd0, wb_empty}, 64'd1);
    chk("reset_u_data_ok", {63'd0, u_data_ok}, 64'd0);
    step(1);
    reset = 1'b0;
    step(1);

    lat = 3;
    issue(32'hBFAF_F000, 32'h1234_5678, 4'hF, 1'b1, 1'b1, 2'd2, 32'h0, w);
    chk("single_same_cycle_accept", w, 0);
    wait_empty("single_drained");
    lat = 0;

    ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      issue(32'hBFC0_0000 + 32'(i * 4), 32'hA000_0000 + 32'(i), 4'hF, 1'b1, 1'b1, 2'd2, 32'h0, w);
      chk("fill_accept", w, 0);
    end
    base = dresp_cnt;
    fork
      issue(32'hBFC0_0014, 32'hA000_0005, 4'hF, 1'b1, 1'b1, 2'd2, 32'h0, w);
      begin
        repeat (3) begin
          @(negedge clk);
          chk("fill_full_stall", {63'd0, u_addr_ok}, 64'd0);
        end
        ready = 1'b1;
      end
    join
    chk("fill_fifth_waits", w, 5);
    chk("fill_after_first_pop", dresp_cnt - base, 1);
`ifdef UCWB_PERF_EN
    chk("perf_full_stall", {32'd0, perf_full_stall}, 64'd5);
`endif
    wait_empty("fill_drained");

    rdata_val = 32'hCAFE_0010;
    issue(32'hBFD0_0010, 32'h0BAD_F00D, 4'h3, 1'b1, 1'b1, 2'd1, 32'h0, w);
    chk("las_store_accept", w, 0);
    issue(32'hBFD0_0010, 32'h0, 4'h0, 1'b0, 1'b1, 2'd2, 32'hCAFE_0010, w);
    chk("las_load_waits_for_drain", w, 3);
`ifdef UCWB_PERF_EN
    chk("perf_pass_stall", {32'd0, perf_pass_stall}, 64'd3);
`endif
    wait_empty("las_done");

    rdata_val = 32'h1357_9BDF;
    rlat = 3;
    issue(32'h8000_0000, 32'h0, 4'h0, 1'b0, 1'b0, 2'd2, 32'h1357_9BDF, w);
    chk("cached_same_cycle", w, 0);
    issue(32'hBFAF_F010, 32'h55AA_55AA, 4'hF, 1'b1, 1'b1, 2'd2, 32'h0, w);
    chk("store_blocked_by_pass", w, 4);
    wait_empty("cached_done");
    rlat = 0;

    ready = 1'b0;
    issue(32'hBFE0_0000, 32'h1111_1111, 4'hF, 1'b1, 1'b1, 2'd2, 32'h0, w);
    issue(32'hBFE0_0004, 32'h2222_2222, 4'hF, 1'b1, 1'b1, 2'd2, 32'h0, w);
    ready = 1'b1;
    wait_hs("pp_first_hs");
    step(1);
    fork
      issue(32'hBFE0_0008, 32'h3333_3333, 4'hC, 1'b1, 1'b1, 2'd1, 32'h0, w);
      begin
        @(negedge clk);
        chk("pp_pop_same_cycle", {63'd0, d_data_ok}, 64'd1);
      end
    join
    chk("pp_push_accept", w, 0);
    @(negedge clk);
    chk("pp_count_kept", {60'd0, dut.count}, 64'd2);
    wait_empty("pp_drained");

    ready = 1'b0;
    rlat = 5;
    for (int i = 0; i < 3; i++)
      issue(32'hBFF0_0000 + 32'(i * 4), 32'hC000_0000 + 32'(i), 4'hF, 1'b1, 1'b1, 2'd2, 32'h0, w);
    ready = 1'b1;
    wait_hs("rst_first_hs");
    step(1);
    @(negedge clk);
    chk("rst_in_d_resp", {63'd0, dut.drain == D_RESP}, 64'd1);
    step(1);
    reset = 1'b1;
    exp_d.delete();
    step(1);
    @(negedge clk);
    chk("rst_mid_d_req", {63'd0, d_req}, 64'd0);
    chk("rst_mid_wb_empty", {63'd0, wb_empty}, 64'd1);
`ifdef UCWB_PERF_EN
    chk("rst_perf_full", {32'd0, perf_full_stall}, 64'd0);
    chk("rst_perf_pass", {32'd0, perf_pass_stall}, 64'd0);
`endif
    step(1);
    reset = 1'b0;
    rlat = 0;
    step(1);
    issue(32'hBFAF_F020, 32'hDEAD_BEEF, 4'hF, 1'b1, 1'b1, 2'd2, 32'h0, w);
    chk("post_reset_accept", w, 0);
    wait_empty("post_reset_drained");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
